// File: rtl/uart_tx_serializer_p_pkg.sv
// Shared constants and types for the UART TX serializer and its parity helper.
package uart_tx_pkg;

  localparam logic PAR_EVEN    = 1'b0;
  localparam logic PAR_ODD     = 1'b1;
  localparam logic LSB_FIRST_C = 1'b0;
  localparam logic MSB_FIRST_C = 1'b1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

endpackage

// File: rtl/uart_tx_serializer_p_if.sv
// Load port of the TX serializer: one word plus its parity type and bit order.
//
// Handshake: a word transfers on a rising clock edge where DATA_VALID && ld_ready.
// The producer (master) drives P_DATA, PAR_TYP and MSB_FIRST alongside DATA_VALID.
// The serializer (slave) drives ld_ready. ld_ready does not depend on DATA_VALID,
// and DATA_VALID while ld_ready=0 is simply ignored (nothing is captured).
interface uart_tx_serializer_p_if #(
  parameter int DATA_WIDTH = 8
);

  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  DATA_VALID;
  logic                  ld_ready;
  logic                  PAR_TYP;
  logic                  MSB_FIRST;

  modport master (
    output P_DATA,
    output DATA_VALID,
    output PAR_TYP,
    output MSB_FIRST,
    input  ld_ready
  );

  modport slave (
    input  P_DATA,
    input  DATA_VALID,
    input  PAR_TYP,
    input  MSB_FIRST,
    output ld_ready
  );

endinterface

// File: rtl/uart_tx_serializer_p_parity_calc.sv
// Combinational parity generator, shared by the TX serializer and the RX checker.
// par_typ = 0 gives even parity (^data), par_typ = 1 gives odd parity (~^data).
module uart_parity_calc #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  par
);

  // Odd parity is the inverted XOR reduction; par_typ selects the inversion.
  assign par = (^data) ^ par_typ;

endmodule

// File: rtl/uart_tx_serializer_p.sv
// Double-buffered parallel-to-serial converter for the UART TX path.
// A one-word holding buffer accepts the next word while the current one shifts;
// each ser_en strobe emits one data bit, and par_bit holds the word's parity.
module uart_tx_serializer_p
  import uart_tx_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  localparam int CNT_W      = $clog2(DATA_WIDTH)
) (
  input  logic                 CLK,
  input  logic                 RST,
  uart_tx_serializer_p_if.slave ld_if,
  input  logic                 ser_en,
  output logic                 ser_data,
  output logic                 ser_done,
  output logic                 par_bit,
  output logic                 ser_busy,
  output logic                 word_avail,
  output ser_state_t           dbg_state,
  output logic [CNT_W-1:0]     dbg_cnt
);

  ser_state_t            r_state, w_nxt_state;
  logic [DATA_WIDTH-1:0] r_hold, r_shreg, w_nxt_shreg, w_ld_norm;
  logic [CNT_W-1:0]      r_cnt, w_nxt_cnt;
  logic                  r_hold_par, r_hold_valid;
  logic                  r_ser_data, w_nxt_ser_data;
  logic                  r_ser_done, w_nxt_ser_done;
  logic                  r_par_bit, w_nxt_par_bit;
  logic                  w_load, w_consume, w_par;

  // Load only into an empty buffer; consume only from a full one, so they never coincide.
  assign w_load         = ld_if.DATA_VALID && !r_hold_valid;
  assign ld_if.ld_ready = !r_hold_valid;

  // Parity uses the normalised hold word; XOR is order-independent, so the
  // result equals the parity of the word as presented on P_DATA.
  uart_parity_calc #(.DATA_WIDTH(DATA_WIDTH)) u_parity (
    .data    (r_hold),
    .par_typ (r_hold_par),
    .par     (w_par)
  );

  // Normalise bit order at load so index 0 is always the first bit on the line.
  always_comb begin
    w_ld_norm = ld_if.P_DATA;
    if (ld_if.MSB_FIRST == MSB_FIRST_C) begin
      for (int i = 0; i < DATA_WIDTH; i++) begin
        w_ld_norm[i] = ld_if.P_DATA[DATA_WIDTH-1-i];
      end
    end
  end

  // Holding buffer: capture on accepted load, release when the shifter takes the word.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_hold       <= '0;
      r_hold_par   <= PAR_EVEN;
      r_hold_valid <= 1'b0;
    end else if (w_consume) begin
      r_hold_valid <= 1'b0;
    end else if (w_load) begin
      r_hold       <= w_ld_norm;
      r_hold_par   <= ld_if.PAR_TYP;
      r_hold_valid <= 1'b1;
    end
  end

  // Shifter state and registered serial outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_shreg    <= '0;
      r_ser_data <= 1'b0;
      r_ser_done <= 1'b0;
      r_par_bit  <= 1'b0;
    end else begin
      r_state    <= w_nxt_state;
      r_cnt      <= w_nxt_cnt;
      r_shreg    <= w_nxt_shreg;
      r_ser_data <= w_nxt_ser_data;
      r_ser_done <= w_nxt_ser_done;
      r_par_bit  <= w_nxt_par_bit;
    end
  end

  // Next-state logic: everything holds unless ser_en advances the shifter.
  always_comb begin
    w_nxt_state    = r_state;
    w_nxt_cnt      = r_cnt;
    w_nxt_shreg    = r_shreg;
    w_nxt_ser_data = r_ser_data;
    w_nxt_ser_done = 1'b0;
    w_nxt_par_bit  = r_par_bit;
    w_consume      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (ser_en && r_hold_valid) begin
          w_nxt_ser_data = r_hold[0];
          w_nxt_shreg    = r_hold;
          w_nxt_cnt      = CNT_W'(1);
          w_nxt_par_bit  = w_par;
          w_consume      = 1'b1;
          w_nxt_state    = SHIFT;
        end
      end
      SHIFT: begin
        if (ser_en) begin
          w_nxt_ser_data = r_shreg[r_cnt];
          if (r_cnt == CNT_W'(DATA_WIDTH-1)) begin
            w_nxt_ser_done = 1'b1;
            w_nxt_cnt      = '0;
            w_nxt_state    = IDLE;
          end else begin
            w_nxt_cnt = r_cnt + CNT_W'(1);
          end
        end
      end
      default: w_nxt_state = IDLE;
    endcase
  end

  assign ser_data   = r_ser_data;
  assign ser_done   = r_ser_done;
  assign par_bit    = r_par_bit;
  assign ser_busy   = (r_state == SHIFT);
  assign word_avail = r_hold_valid;
  assign dbg_state  = r_state;
  assign dbg_cnt    = r_cnt;

endmodule

// File: tb/tb_uart_tx_serializer_p.sv
// Bench for uart_tx_serializer_p: an 8-bit and a 5-bit instance, directed vectors,
// expected serial outputs queued per ser_en strobe and checked by a monitor.
module tb_uart_tx_serializer_p;
  import uart_tx_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  uart_tx_serializer_p_if #(.DATA_WIDTH(8)) ld8 ();
  uart_tx_serializer_p_if #(.DATA_WIDTH(5)) ld5 ();

  logic       ser_en8, ser_data8, ser_done8, par_bit8, ser_busy8, word_avail8;
  logic       ser_en5, ser_data5, ser_done5, par_bit5, ser_busy5, word_avail5;
  ser_state_t dbg_state8, dbg_state5;
  logic [2:0] dbg_cnt8, dbg_cnt5;

  uart_tx_serializer_p #(.DATA_WIDTH(8)) u_dut8 (
    .CLK(clk), .RST(rst_n), .ld_if(ld8), .ser_en(ser_en8),
    .ser_data(ser_data8), .ser_done(ser_done8), .par_bit(par_bit8),
    .ser_busy(ser_busy8), .word_avail(word_avail8),
    .dbg_state(dbg_state8), .dbg_cnt(dbg_cnt8)
  );

  uart_tx_serializer_p #(.DATA_WIDTH(5)) u_dut5 (
    .CLK(clk), .RST(rst_n), .ld_if(ld5), .ser_en(ser_en5),
    .ser_data(ser_data5), .ser_done(ser_done5), .par_bit(par_bit5),
    .ser_busy(ser_busy5), .word_avail(word_avail5),
    .dbg_state(dbg_state5), .dbg_cnt(dbg_cnt5)
  );

  // ---------------- scoreboard ----------------
  // Entry layout: {ser_data, ser_done, par_bit, ser_busy} after a strobed edge.
  logic [3:0] exp8_q[$];
  logic [3:0] exp5_q[$];
  logic [3:0] last8 = 4'b0000;
  logic [3:0] last5 = 4'b0000;
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  logic en_d8 = 1'b0;
  logic en_d5 = 1'b0;
  always @(posedge clk) begin
    en_d8 <= ser_en8;
    en_d5 <= ser_en5;
  end

  always @(negedge clk) begin
    logic [3:0] e;
    if (en_d8) begin
      if (exp8_q.size() == 0) begin
        chk("mon8_queue_empty", 8'd1, 8'd0);
      end else begin
        e = exp8_q.pop_front();
        chk("mon8_strobe", {4'b0, ser_data8, ser_done8, par_bit8, ser_busy8}, {4'b0, e});
        last8 = e;
      end
    end else begin
      chk("mon8_hold", {4'b0, ser_data8, ser_done8, par_bit8, ser_busy8},
          {4'b0, last8[3], 1'b0, last8[1], last8[0]});
    end
    if (en_d5) begin
      if (exp5_q.size() == 0) begin
        chk("mon5_queue_empty", 8'd1, 8'd0);
      end else begin
        e = exp5_q.pop_front();
        chk("mon5_strobe", {4'b0, ser_data5, ser_done5, par_bit5, ser_busy5}, {4'b0, e});
        last5 = e;
      end
    end else begin
      chk("mon5_hold", {4'b0, ser_data5, ser_done5, par_bit5, ser_busy5},
          {4'b0, last5[3], 1'b0, last5[1], last5[0]});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a word; exp_ready is the hand-predicted ld_ready at the moment of the offer.
  task automatic load(input bit sel5, input logic [7:0] data, input logic pt,
                      input logic msb, input logic exp_ready);
    if (sel5) begin
      chk("ld5_ready_pre", {7'b0, ld5.ld_ready}, {7'b0, exp_ready});
      ld5.P_DATA = data[4:0]; ld5.PAR_TYP = pt; ld5.MSB_FIRST = msb; ld5.DATA_VALID = 1'b1;
      tick();
      ld5.DATA_VALID = 1'b0;
      chk("ld5_word_avail", {7'b0, word_avail5}, 8'd1);
    end else begin
      chk("ld8_ready_pre", {7'b0, ld8.ld_ready}, {7'b0, exp_ready});
      ld8.P_DATA = data; ld8.PAR_TYP = pt; ld8.MSB_FIRST = msb; ld8.DATA_VALID = 1'b1;
      tick();
      ld8.DATA_VALID = 1'b0;
      chk("ld8_word_avail", {7'b0, word_avail8}, 8'd1);
    end
  endtask

  task automatic strobe(input bit sel5, input logic b, input logic d,
                        input logic p, input logic bz);
    if (sel5) begin
      exp5_q.push_back({b, d, p, bz});
      ser_en5 = 1'b1;
    end else begin
      exp8_q.push_back({b, d, p, bz});
      ser_en8 = 1'b1;
    end
    tick();
    ser_en8 = 1'b0;
    ser_en5 = 1'b0;
  endtask

  // stream[i] is the hand-derived i-th bit on the line; bits from..n-1 are strobed.
  task automatic shift_from(input bit sel5, input logic [7:0] stream, input int n,
                            input logic p, input int gap, input int from);
    for (int i = from; i < n; i++) begin
      strobe(sel5, stream[i], (i == n-1), p, (i != n-1));
      repeat (gap) tick();
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    ser_en8 = 1'b0; ser_en5 = 1'b0;
    ld8.P_DATA = '0; ld8.DATA_VALID = 1'b0; ld8.PAR_TYP = 1'b0; ld8.MSB_FIRST = 1'b0;
    ld5.P_DATA = '0; ld5.DATA_VALID = 1'b0; ld5.PAR_TYP = 1'b0; ld5.MSB_FIRST = 1'b0;
    repeat (3) tick();

    // Power-on reset values
    chk("rst_outputs", {4'b0, ser_data8, ser_done8, par_bit8, ser_busy8}, 8'h00);
    chk("rst_ld_ready", {7'b0, ld8.ld_ready}, 8'd1);
    chk("rst_word_avail", {7'b0, word_avail8}, 8'd0);
    chk("rst_state", 8'(dbg_state8), 8'(IDLE));
    chk("rst_cnt", {5'b0, dbg_cnt8}, 8'd0);
    rst_n = 1'b1;
    tick();

    // Reset mid-shift of 0xC1 with a second word waiting in the hold buffer
    load(1'b0, 8'hC1, PAR_EVEN, LSB_FIRST_C, 1'b1);
    strobe(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    strobe(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    strobe(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    load(1'b0, 8'h0F, PAR_ODD, LSB_FIRST_C, 1'b1);
    rst_n = 1'b0;
    last8 = 4'b0000;
    #2;
    chk("midrst_outputs", {4'b0, ser_data8, ser_done8, par_bit8, ser_busy8}, 8'h00);
    chk("midrst_ld_ready", {7'b0, ld8.ld_ready}, 8'd1);
    chk("midrst_word_avail", {7'b0, word_avail8}, 8'd0);
    chk("midrst_state", 8'(dbg_state8), 8'(IDLE));
    chk("midrst_cnt", {5'b0, dbg_cnt8}, 8'd0);
    tick();
    rst_n = 1'b1;
    tick();
    // Clean restart at bit 0: 0x81 even, LSB first -> 1,0,0,0,0,0,0,1 parity 0
    load(1'b0, 8'h81, PAR_EVEN, LSB_FIRST_C, 1'b1);
    shift_from(1'b0, 8'b1000_0001, 8, 1'b0, 0, 0);
    chk("restart_cnt", {5'b0, dbg_cnt8}, 8'd0);

    // 0xC1 even, LSB first, consecutive strobes -> 1,0,0,0,0,0,1,1 parity 1
    load(1'b0, 8'hC1, PAR_EVEN, LSB_FIRST_C, 1'b1);
    shift_from(1'b0, 8'b1100_0001, 8, 1'b1, 0, 0);

    // 0xC1 odd, MSB first, strobe every 3rd cycle -> 1,1,0,0,0,0,0,1 parity 0
    load(1'b0, 8'hC1, PAR_ODD, MSB_FIRST_C, 1'b1);
    shift_from(1'b0, 8'b1000_0011, 8, 1'b0, 2, 0);

    // Back-to-back: 0xA5 even then 0x0F odd, loaded while 0xA5 shifts
    load(1'b0, 8'hA5, PAR_EVEN, LSB_FIRST_C, 1'b1);
    strobe(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    load(1'b0, 8'h0F, PAR_ODD, LSB_FIRST_C, 1'b1);
    chk("b2b_ld_ready_full", {7'b0, ld8.ld_ready}, 8'd0);
    shift_from(1'b0, 8'b1010_0101, 8, 1'b0, 0, 1);
    strobe(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("b2b_ld_ready_after_consume", {7'b0, ld8.ld_ready}, 8'd1);
    shift_from(1'b0, 8'b0000_1111, 8, 1'b1, 0, 1);

    // Hold full: 0xB5 odd accepted, 0x00 and 0xFF offered while full are dropped
    load(1'b0, 8'hB5, PAR_ODD, LSB_FIRST_C, 1'b1);
    load(1'b0, 8'h00, PAR_EVEN, LSB_FIRST_C, 1'b0);
    load(1'b0, 8'hFF, PAR_EVEN, MSB_FIRST_C, 1'b0);
    chk("full_ld_ready", {7'b0, ld8.ld_ready}, 8'd0);
    strobe(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("full_ld_ready_after_consume", {7'b0, ld8.ld_ready}, 8'd1);
    shift_from(1'b0, 8'b1011_0101, 8, 1'b0, 0, 1);
    // ser_en in IDLE with empty hold: nothing changes
    strobe(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("idle_empty_state", 8'(dbg_state8), 8'(IDLE));
    chk("idle_empty_word_avail", {7'b0, word_avail8}, 8'd0);

    // DATA_WIDTH=5: 5'b10110 even, LSB first -> 0,1,1,0,1 parity 1
    load(1'b1, 8'h16, PAR_EVEN, LSB_FIRST_C, 1'b1);
    shift_from(1'b1, 8'b0001_0110, 5, 1'b1, 0, 0);
    chk("w5_cnt_wrap", {5'b0, dbg_cnt5}, 8'd0);
    chk("w5_state", 8'(dbg_state5), 8'(IDLE));
    // 5'b10011 odd, MSB first -> 1,0,0,1,1 parity 0
    load(1'b1, 8'h13, PAR_ODD, MSB_FIRST_C, 1'b1);
    shift_from(1'b1, 8'b0001_1001, 5, 1'b0, 1, 0);
    chk("w5_cnt_wrap2", {5'b0, dbg_cnt5}, 8'd0);

    repeat (3) tick();
    chk("exp8_drained", 8'(exp8_q.size()), 8'd0);
    chk("exp5_drained", 8'(exp5_q.size()), 8'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
